// File: rtl/i2s_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2s_pkg : shared I2S constants and state encoding (rx and tx)    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package i2s_pkg;

  localparam int   I2S_WIDTH  = 16;
  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

endpackage
`default_nettype wire

// File: rtl/i2s_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2s_sync_edge : multi-flop synchroniser, rising-edge detect bit 0 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int BITS        = 1
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic [BITS-1:0] async_i,
  output logic [BITS-1:0] sync_o,
  output logic            rise_o
);

  logic [BITS-1:0] stage_q [SYNC_STAGES];
  logic            dly_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      dly_q <= 1'b0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      dly_q <= stage_q[SYNC_STAGES-1][0];
    end
  end

  // All bits share the same latency, so the other bits stay aligned to bit 0's edge.
  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = sync_o[0] & ~dly_q;

endmodule
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i2s_rx : Philips-format I2S receiver, stereo pair per frame      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int WIDTH       = I2S_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i2s_bclk,
  input  logic             i2s_lrck,
  input  logic             i2s_sdata,
  output logic [WIDTH-1:0] left_data,
  output logic [WIDTH-1:0] right_data,
  output logic             sample_valid,
  output logic             frame_err
);

  localparam int              C_CNT_W     = $clog2(WIDTH + 1);
  localparam logic [C_CNT_W-1:0] C_WIDTH_CNT = C_CNT_W'(WIDTH);
  localparam logic [C_CNT_W-1:0] C_ONE       = {{(C_CNT_W-1){1'b0}}, 1'b1};

  logic [2:0] w_sync;
  logic       w_bclk_rise;
  logic       w_lrck_s;
  logic       w_sdata_s;
  logic       w_change;

  i2s_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .BITS        (3)
  ) u_sync (
    .clk     (clk),
    .rst_i   (reset),
    .async_i ({i2s_sdata, i2s_lrck, i2s_bclk}),
    .sync_o  (w_sync),
    .rise_o  (w_bclk_rise)
  );

  assign w_lrck_s  = w_sync[1];
  assign w_sdata_s = w_sync[2];

  i2s_state_e         state_q,      state_d;
  logic               lrck_prev_q,  lrck_prev_d;
  logic [WIDTH-1:0]   shreg_q,      shreg_d;
  logic [C_CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0]   left_stage_q, left_stage_d;
  logic               left_cap_q,   left_cap_d;
  logic [WIDTH-1:0]   left_q,       left_d;
  logic [WIDTH-1:0]   right_q,      right_d;
  logic               valid_q,      valid_d;
  logic               err_q,        err_d;

  logic [WIDTH-1:0]   w_shift;
  logic [C_CNT_W-1:0] w_cnt;
  logic [WIDTH-1:0]   w_word;

  assign w_change = (w_lrck_s != lrck_prev_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      lrck_prev_q  <= 1'b0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      left_stage_q <= '0;
      left_cap_q   <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lrck_prev_q  <= lrck_prev_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      left_stage_q <= left_stage_d;
      left_cap_q   <= left_cap_d;
      left_q       <= left_d;
      right_q      <= right_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lrck_prev_d  = lrck_prev_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    left_stage_d = left_stage_q;
    left_cap_d   = left_cap_q;
    left_d       = left_q;
    right_d      = right_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    w_shift      = shreg_q;
    w_cnt        = cnt_q;
    w_word       = '0;

    if (w_bclk_rise) begin
      lrck_prev_d = w_lrck_s;
      unique case (state_q)
        ST_HUNT: begin
          if (w_change) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          // Bits beyond WIDTH (e.g. 32-bit slot padding) are dropped.
          if (w_cnt < C_WIDTH_CNT) begin
            w_shift = {w_shift[WIDTH-2:0], w_sdata_s};
            w_cnt   = w_cnt + C_ONE;
          end
          shreg_d = w_shift;
          cnt_d   = w_cnt;
          if (w_change) begin
            // Short slots are MSB-justified with zero-filled LSBs.
            w_word = w_shift << (C_WIDTH_CNT - w_cnt);
            err_d  = (w_cnt < C_WIDTH_CNT);
            if (lrck_prev_q == LRCK_LEFT) begin
              left_stage_d = w_word;
              left_cap_d   = 1'b1;
            end else if ((lrck_prev_q == LRCK_RIGHT) && left_cap_q) begin
              left_d     = left_stage_q;
              right_d    = w_word;
              valid_d    = 1'b1;
              left_cap_d = 1'b0;
            end
            cnt_d = '0;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_i2s_rx : directed self-checking bench for i2s_rx              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_i2s_rx;

  localparam int WIDTH = 16;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             bclk  = 1'b0;
  logic             lrck  = 1'b0;
  logic             sdata = 1'b0;
  logic [WIDTH-1:0] left_data;
  logic [WIDTH-1:0] right_data;
  logic             sample_valid;
  logic             frame_err;

  int n_cmp = 0;
  int n_mis = 0;

  int               cyc       = 0;
  int               n_valid   = 0;
  int               n_err     = 0;
  int               prev_vcyc = -1;
  int               spacing   = 0;
  logic [WIDTH-1:0] last_l    = '0;
  logic [WIDTH-1:0] last_r    = '0;
  logic             last_err_v = 1'b0;

  logic [15:0] ltone [4] = '{16'h30FB, 16'h5A82, 16'h7641, 16'h7FFF};
  logic [15:0] rtone [4] = '{16'hCF05, 16'hA57E, 16'h89BF, 16'h8001};

  i2s_rx #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i2s_bclk     (bclk),
    .i2s_lrck     (lrck),
    .i2s_sdata    (sdata),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid) begin
      n_valid++;
      last_l     = left_data;
      last_r     = right_data;
      last_err_v = frame_err;
      if (prev_vcyc >= 0) spacing = cyc - prev_vcyc;
      prev_vcyc = cyc;
    end
    if (frame_err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Pins change on the BCLK falling edge; the receiver samples on the rise.
  task automatic tx_bit(input logic lr, input logic d, input int half);
    bclk  = 1'b0;
    lrck  = lr;
    sdata = d;
    repeat (half) @(negedge clk);
    bclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // Philips timing: the LSB of a slot already carries the next slot's LRCK.
  task automatic tx_slot(input logic ch, input logic [31:0] word, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      tx_bit((i == 0) ? ~ch : ch, word[i], half);
    end
  endtask

  task automatic tx_frame(input logic [31:0] l, input logic [31:0] r, input int n, input int half);
    tx_slot(1'b0, l, n, half);
    tx_slot(1'b1, r, n, half);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bv;
    int be;

    repeat (3) @(negedge clk);
    chk("rst_left",  left_data,    0);
    chk("rst_right", right_data,   0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_err",   frame_err,    0);
    reset = 1'b0;

    // 16-bit slots at clk/8: the first frame is swallowed while hunting.
    bv = n_valid; be = n_err;
    tx_frame(32'hA5C3, 32'h1234, 16, 4);
    chk("hunt_discard", n_valid - bv, 0);
    tx_frame(32'hA5C3, 32'h1234, 16, 4);
    tx_frame(32'hA5C3, 32'h1234, 16, 4);
    chk("t16_nvalid",  n_valid - bv, 2);
    chk("t16_left",    last_l, 16'hA5C3);
    chk("t16_right",   last_r, 16'h1234);
    chk("t16_err",     n_err - be, 0);
    chk("t16_spacing", spacing, 256);

    // 32-bit slots: only the top WIDTH bits are kept.
    bv = n_valid; be = n_err;
    tx_frame(32'hBEEF0001, 32'h0F0FFFFF, 32, 4);
    chk("t32_nvalid",  n_valid - bv, 1);
    chk("t32_left",    last_l, 16'hBEEF);
    chk("t32_right",   last_r, 16'h0F0F);
    chk("t32_err",     n_err - be, 0);
    chk("t32_spacing", spacing, 512);

    // Short right slot of 12 bits.
    bv = n_valid; be = n_err;
    tx_slot(1'b0, 32'h8001, 16, 4);
    tx_slot(1'b1, 32'h0ABC, 12, 4);
    chk("short_nvalid",  n_valid - bv, 1);
    chk("short_left",    last_l, 16'h8001);
    chk("short_right",   last_r, 16'hABC0);
    chk("short_err_v",   last_err_v, 1);
    chk("short_nerr",    n_err - be, 1);

    // Reset in the middle of a left slot.
    for (int i = 15; i >= 8; i--) tx_bit(1'b0, 1'b1, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_left",  left_data,    0);
    chk("midrst_right", right_data,   0);
    chk("midrst_valid", sample_valid, 0);
    bv = n_valid; be = n_err;
    for (int i = 7; i >= 0; i--) tx_bit((i == 0) ? 1'b1 : 1'b0, 1'b1, 4);
    tx_slot(1'b1, 32'h2222, 16, 4);
    chk("midrst_novalid", n_valid - bv, 0);
    tx_frame(32'h3333, 32'h4444, 16, 4);
    chk("midrst_nvalid", n_valid - bv, 1);
    chk("midrst_l",      last_l, 16'h3333);
    chk("midrst_r",      last_r, 16'h4444);
    chk("midrst_err",    n_err - be, 0);

    // Transmitter-style stream at clk/64 carrying tone samples.
    bv = n_valid; be = n_err;
    for (int f = 0; f < 4; f++) begin
      tx_frame({16'h0, ltone[f]}, {16'h0, rtone[f]}, 16, 32);
      chk($sformatf("lb%0d_nvalid", f), n_valid - bv, f + 1);
      chk($sformatf("lb%0d_left", f),   last_l, {16'h0, ltone[f]});
      chk($sformatf("lb%0d_right", f),  last_r, {16'h0, rtone[f]});
      if (f > 0) chk($sformatf("lb%0d_spacing", f), spacing, 2048);
    end
    chk("lb_err", n_err - be, 0);

    // BCLK parked high.
    bv = n_valid; be = n_err;
    repeat (1000) @(negedge clk);
    chk("idle_nvalid", n_valid - bv, 0);
    chk("idle_nerr",   n_err - be, 0);
    chk("idle_left",   left_data,  {16'h0, ltone[3]});
    chk("idle_right",  right_data, {16'h0, rtone[3]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
